// File: rtl/s_div_sched_pkg.sv
// s_div_sched_pkg: shared types and sizes for the divider scheduler.
package s_div_sched_pkg;
    localparam int DIV_N_BITS = 32;
    localparam int N_DIV_REQ = 4;
    typedef enum logic [2:0] {IDLE, LOAD, CALC, FIX, RESP} div_sched_state_t;
    typedef struct packed {
        logic rsvd;
        logic sgn;
    } div_op_t;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/s_div_sched_if.sv
// s_div_sched_if: request/response bundle between division PEs and the scheduler.
interface s_div_sched_if
    import s_div_sched_pkg::*;
#(
    parameter int N_BITS = DIV_N_BITS,
    parameter int N_REQ = N_DIV_REQ,
    parameter int LOG_N_REQ = idx_w(N_REQ)
);
    logic [N_REQ-1:0] req_valid;
    logic [N_REQ-1:0][N_BITS-1:0] req_a;
    logic [N_REQ-1:0][N_BITS-1:0] req_b;
    div_op_t [N_REQ-1:0] req_op;
    logic [N_REQ-1:0] req_ready;
    logic [N_REQ-1:0] resp_valid;
    logic [N_BITS-1:0] resp_q;
    logic [N_BITS-1:0] resp_r;
    logic [LOG_N_REQ-1:0] grant_id;
    modport master (
        output req_valid, req_a, req_b, req_op,
        input req_ready, resp_valid, resp_q, resp_r, grant_id
    );
    modport slave (
        input req_valid, req_a, req_b, req_op,
        output req_ready, resp_valid, resp_q, resp_r, grant_id
    );
endinterface

// File: rtl/s_div_seq_core.sv
// s_div_seq_core: unsigned restoring divider, one quotient bit per enabled cycle.
module s_div_seq_core #(
    parameter int N_BITS = 32
) (
    input  logic              clk_cg,
    input  logic              rst_n_i,
    input  logic              start,
    input  logic              en,
    input  logic [N_BITS-1:0] a,
    input  logic [N_BITS-1:0] b,
    output logic              done,
    output logic [N_BITS-1:0] q,
    output logic [N_BITS-1:0] r
);
    localparam int CW = $clog2(N_BITS);
    logic [CW-1:0] cnt;
    logic run;
    logic [N_BITS-1:0] dvs;
    logic [N_BITS:0] sh;
    logic ge;
    // q doubles as the dividend shift register; its MSB feeds the partial remainder
    assign sh = {r, q[N_BITS-1]};
    assign ge = sh >= {1'b0, dvs};
    assign done = run && cnt == CW'(N_BITS - 1);
    always_ff @(posedge clk_cg or negedge rst_n_i) begin
        if (!rst_n_i) begin
            q <= '0;
            r <= '0;
            dvs <= '0;
            cnt <= '0;
            run <= 1'b0;
        end else if (en) begin
            if (start) begin
                r <= '0;
                q <= a;
                dvs <= b;
                cnt <= '0;
                run <= 1'b1;
            end else if (run) begin
                r <= ge ? sh[N_BITS-1:0] - dvs : sh[N_BITS-1:0];
                q <= {q[N_BITS-2:0], ge};
                cnt <= cnt + CW'(1);
                run <= !done;
            end
        end
    end
endmodule

// File: rtl/s_div_sched.sv
// s_div_sched: round-robin owner of one shared divider; arbitrates, sequences, sign-fixes, replies.
// Define MAGE_DIV_EARLY_OUT_EN to skip the iterative phase when b==0 or |a|<|b|.
module s_div_sched
    import s_div_sched_pkg::*;
#(
    parameter int N_BITS = DIV_N_BITS,
    parameter int N_REQ = N_DIV_REQ,
    parameter int LOG_N_REQ = idx_w(N_REQ)
) (
    input  logic      clk_cg,
    input  logic      rst_n_i,
    input  logic      mage_done,
    input  logic      pea_ready,
    output logic      busy,
    s_div_sched_if.slave bus
);
    div_sched_state_t state, state_nxt;
    logic [LOG_N_REQ-1:0] rr_ptr, gnt, owner;
    logic found, accept, early, sa, sb, bz, sgn_q, early_q, start, done;
    logic [N_BITS-1:0] a_q, b_q, abs_a, abs_b, core_q, core_r, raw_q, raw_r, q_res, r_res;

    always_comb begin
        found = 1'b0;
        gnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && bus.req_valid[(int'(rr_ptr) + i) % N_REQ]) begin
                found = 1'b1;
                gnt = LOG_N_REQ'((int'(rr_ptr) + i) % N_REQ);
            end
        end
    end

    assign accept = state == IDLE && pea_ready && !mage_done && found;
    assign sa = a_q[N_BITS-1];
    assign sb = b_q[N_BITS-1];
    assign abs_a = sa ? -a_q : a_q;
    assign abs_b = sb ? -b_q : b_q;
    assign bz = b_q == '0;
    assign start = state == LOAD;
`ifdef MAGE_DIV_EARLY_OUT_EN
    assign early = bz || abs_a < abs_b;
`else
    assign early = 1'b0;
`endif
    // early-out results come straight from the operands instead of the core
    assign raw_q = early_q ? {N_BITS{bz}} : core_q;
    assign raw_r = early_q ? abs_a : core_r;

    s_div_seq_core #(.N_BITS(N_BITS)) u_core (
        .clk_cg(clk_cg),
        .rst_n_i(rst_n_i),
        .start(start),
        .en(pea_ready),
        .a(abs_a),
        .b(abs_b),
        .done(done),
        .q(core_q),
        .r(core_r)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: state_nxt = accept ? LOAD : IDLE;
            LOAD: state_nxt = early ? FIX : CALC;
            CALC: state_nxt = done ? FIX : CALC;
            FIX: state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_cg or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
            rr_ptr <= '0;
            owner <= '0;
            a_q <= '0;
            b_q <= '0;
            sgn_q <= 1'b0;
            early_q <= 1'b0;
            q_res <= '0;
            r_res <= '0;
        end else if (mage_done) begin
            state <= IDLE;
            rr_ptr <= '0;
            owner <= '0;
            q_res <= '0;
            r_res <= '0;
        end else if (pea_ready) begin
            state <= state_nxt;
            if (accept) begin
                owner <= gnt;
                a_q <= bus.req_a[gnt];
                b_q <= bus.req_b[gnt];
                sgn_q <= bus.req_op[gnt].sgn;
                rr_ptr <= LOG_N_REQ'((int'(gnt) + 1) % N_REQ);
            end
            if (state == LOAD)
                early_q <= early;
            if (state == FIX) begin
                q_res <= bz ? '1 : (sgn_q && (sa ^ sb)) ? -raw_q : raw_q;
                r_res <= (sgn_q && sa) ? -raw_r : raw_r;
            end
        end
    end

    assign bus.req_ready = accept ? N_REQ'(1) << gnt : '0;
    assign bus.resp_valid = (state == RESP) ? N_REQ'(1) << owner : '0;
    assign bus.resp_q = q_res;
    assign bus.resp_r = r_res;
    assign bus.grant_id = owner;
    assign busy = state != IDLE;
endmodule
